fdiv_iter: RTL and testbench

//   Iterative single-precision (binary32) divider, y = x1 / x2, the inverse operation of the FPU multiplier.

---
 rtl/fdiv_iter.sv | 153 +++++++++++++++
 tb/tb_fdiv_iter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_iter.sv
// Iterative binary32 divider, y = x1 / x2.
// Restoring division producing one quotient bit per cycle (25 cycles),
// followed by normalisation and range/special-case resolution.
// Number model matches the FPU multiplier: denormals flush to zero,
// truncation, no NaN generation; exponent 255 is an ordinary exponent.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for operands; accept latches sign, mantissas, exponent
// CALC  | one restoring-division step per cycle, cnt 0..24
// DONE  | result held on y with out_valid=1 until out_ready

module fdiv_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] y,
   output logic        out_valid,
   input  logic        out_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               sy_q, sy_d;
   logic [23:0]        m2_q, m2_d;
   logic signed [9:0]  ed_q, ed_d;
   logic               z1_q, z1_d;
   logic               z2_q, z2_d;
   logic [25:0]        rem_q, rem_d;
   // Only the lower 24 quotient bits need storing; the 25th bit exists
   // only in the final step's combinational value q_full.
   logic [23:0]        q_q, q_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [31:0]        y_q, y_d;

   logic               ge;
   logic [25:0]        diff;
   logic [25:0]        kept;
   logic [25:0]        rem_step;
   logic [24:0]        q_full;
   logic signed [9:0]  exp_n;
   logic [22:0]        mant;
   logic [31:0]        result;

   // One restoring-division step plus normalisation of the resulting quotient.
   always_comb begin
      ge       = (rem_q >= {2'b00, m2_q});
      diff     = rem_q - {2'b00, m2_q};
      kept     = ge ? diff : rem_q;
      rem_step = kept << 1;
      q_full   = {q_q, ge};
      if (q_full[24]) begin
         exp_n = ed_q;
         mant  = q_full[23:1];
      end else begin
         exp_n = ed_q - 10'sd1;
         mant  = q_full[22:0];
      end
      if (z2_q)
         result = {sy_q, 8'hFF, 23'h0};
      else if (z1_q)
         result = {sy_q, 31'h0};
      else if (exp_n <= 10'sd0)
         result = {sy_q, 31'h0};
      else if (exp_n >= 10'sd255)
         result = {sy_q, 8'hFF, 23'h0};
      else
         result = {sy_q, exp_n[7:0], mant};
   end

   // Next-state and datapath register updates.
   always_comb begin
      state_d = state_q;
      sy_d    = sy_q;
      m2_d    = m2_q;
      ed_d    = ed_q;
      z1_d    = z1_q;
      z2_d    = z2_q;
      rem_d   = rem_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = CALC;
               sy_d    = x1[31] ^ x2[31];
               m2_d    = {1'b1, x2[22:0]};
               ed_d    = $signed({2'b00, x1[30:23]}) - $signed({2'b00, x2[30:23]}) + 10'sd127;
               z1_d    = (x1[30:23] == 8'd0);
               z2_d    = (x2[30:23] == 8'd0);
               rem_d   = {2'b00, 1'b1, x1[22:0]};
               q_d     = '0;
               cnt_d   = '0;
            end
         end
         CALC: begin
            rem_d = rem_step;
            q_d   = q_full[23:0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd24) begin
               state_d = DONE;
               y_d     = result;
            end
         end
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sy_q    <= 1'b0;
         m2_q    <= '0;
         ed_q    <= '0;
         z1_q    <= 1'b0;
         z2_q    <= 1'b0;
         rem_q   <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         sy_q    <= sy_d;
         m2_q    <= m2_d;
         ed_q    <= ed_d;
         z1_q    <= z1_d;
         z2_q    <= z2_d;
         rem_q   <= rem_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign y         = y_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Testbench for fdiv_iter: directed cases, randomized ops against a
// behavioural model, back-pressure, back-to-back and mid-operation reset.

module tb_fdiv_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] x1 = '0;
   logic [31:0] x2 = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] y;
   logic        out_valid;
   logic        out_ready = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   fdiv_iter dut (
      .clk       (clk),
      .rst       (rst),
      .x1        (x1),
      .x2        (x2),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   // Quotient from plain integer arithmetic on the real mantissas.
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic       s;
      int         e1, e2, e;
      longint     num, den, q;
      logic [22:0] m;
      s  = a[31] ^ b[31];
      e1 = int'(a[30:23]);
      e2 = int'(b[30:23]);
      if (e2 == 0) return {s, 8'hFF, 23'h0};
      if (e1 == 0) return {s, 31'h0};
      num = (longint'(a[22:0]) + 64'd8388608) * 64'd16777216;
      den = longint'(b[22:0]) + 64'd8388608;
      q   = num / den;
      e   = e1 - e2 + 127;
      if (q >= 64'd16777216) begin
         m = 23'((q / 2) % 64'd8388608);
      end else begin
         m = 23'(q % 64'd8388608);
         e = e - 1;
      end
      if (e <= 0)   return {s, 31'h0};
      if (e >= 255) return {s, 8'hFF, 23'h0};
      return {s, 8'(e), m};
   endfunction

   // Present operands, wait for accept, scramble inputs, then count cycles
   // until out_valid. lat is the cycle index (accept cycle = 0) of first
   // out_valid, or -1 on timeout. Leaves the result pending.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] yo, output int lat);
      int w;
      x1 = a;
      x2 = b;
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      x1 = $urandom;
      x2 = $urandom;
      lat = 1;
      while (!out_valid && lat < 80) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) lat = -1;
      yo = y;
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({in_ready, out_valid, y} !== {1'b1, 1'b0, 32'h0}) begin
         n_err++;
         $display("FAIL reset: in_ready=%b out_valid=%b y=%h, want 1 0 00000000", in_ready, out_valid, y);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [31:0] va [6] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h00800000, 32'h7F000000};
      logic [31:0] vb [6] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h40000000, 32'h7F000000, 32'h00800000};
      logic [31:0] ve [6] = '{32'h40400000, 32'h3EAAAAAA, 32'hFF800000, 32'h00000000, 32'h00000000, 32'h7F800000};
      logic [31:0] yo;
      int lat;
      for (int i = 0; i < 6; i++) begin
         do_op(va[i], vb[i], yo, lat);
         n_cmp++;
         if (yo !== ve[i]) begin
            n_err++;
            $display("FAIL directed_y[%0d] %h/%h: got %h, want %h", i, va[i], vb[i], yo, ve[i]);
         end
         n_cmp++;
         if (lat != 26) begin
            n_err++;
            $display("FAIL directed_latency[%0d]: got %0d, want 26", i, lat);
         end
         pop();
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, yo, exp_y;
      int lat, pick;
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         b = $urandom;
         pick = $urandom_range(0, 9);
         if (pick == 0) a[30:23] = 8'd0;
         if (pick == 1) b[30:23] = 8'd0;
         if (pick >= 5) begin
            a[30:23] = 8'($urandom_range(100, 154));
            b[30:23] = 8'($urandom_range(100, 154));
         end
         exp_y = ref_div(a, b);
         do_op(a, b, yo, lat);
         n_cmp++;
         if (yo !== exp_y || lat != 26) begin
            n_err++;
            $display("FAIL random[%0d] %h/%h: got y=%h lat=%0d, want y=%h lat=26", i, a, b, yo, lat, exp_y);
         end
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         n_cmp++;
         if (y !== exp_y || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL random_hold[%0d]: got y=%h ov=%b, want y=%h ov=1", i, y, out_valid, exp_y);
         end
         pop();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] yo;
      int lat;
      do_op(32'h3F800000, 32'h40400000, yo, lat);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (y !== 32'h3EAAAAAA || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure[%0d]: y=%h ov=%b ir=%b, want 3eaaaaaa 1 0", k, y, out_valid, in_ready);
         end
      end
      pop();
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL release: ir=%b ov=%b, want 1 0", in_ready, out_valid);
      end
      do_op(32'hC1200000, 32'h40000000, yo, lat);
      n_cmp++;
      if (yo !== ref_div(32'hC1200000, 32'h40000000) || lat != 26) begin
         n_err++;
         $display("FAIL back_to_back: got y=%h lat=%0d, want y=%h lat=26", yo, lat, ref_div(32'hC1200000, 32'h40000000));
      end
      pop();
   endtask

   task automatic test_reset_mid();
      logic [31:0] yo;
      int lat;
      x1 = 32'h40C00000;
      x2 = 32'h40000000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++;
      if ({in_ready, out_valid, y} !== {1'b1, 1'b0, 32'h0}) begin
         n_err++;
         $display("FAIL reset_mid: ir=%b ov=%b y=%h, want 1 0 00000000", in_ready, out_valid, y);
      end
      repeat (30) begin
         @(posedge clk); #1;
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_no_result: ov=%b, want 0", out_valid);
         end
      end
      do_op(32'h40C00000, 32'h40000000, yo, lat);
      n_cmp++;
      if (yo !== 32'h40400000 || lat != 26) begin
         n_err++;
         $display("FAIL after_reset_op: got y=%h lat=%0d, want 40400000 26", yo, lat);
      end
      pop();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
